// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider with pipeline stall request.
// Define DIV_SIGNED_EN to honour the Signed input; otherwise all divides are unsigned.
module iterative_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             DivStall,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             div_by_zero_d;

  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic [WIDTH:0]   partial, diff;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             last_iter;
  logic             accept;

  assign accept = (state_q == StIdle) && Start;

  // Partial remainder stays below the divisor, so a WIDTH+1-bit difference carries the sign.
  assign partial   = {rem_q, quo_q[WIDTH-1]};
  assign diff      = partial - {1'b0, dvsr_q};
  assign step_rem  = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quo  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign last_iter = (count_q == CntW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  always_comb begin
    abs_dividend = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    abs_divisor  = (Signed && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    if (accept) begin
      neg_quo_d = Signed && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
      neg_rem_d = Signed && Dividend[WIDTH-1];
    end
    fix_quo = neg_quo_q ? -step_quo : step_quo;
    fix_rem = neg_rem_q ? -step_rem : step_rem;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = Signed;
  assign abs_dividend  = Dividend;
  assign abs_divisor   = Divisor;
  assign fix_quo       = step_quo;
  assign fix_rem       = step_rem;
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvsr_d        = dvsr_q;
    quotient_d    = Quotient;
    remainder_d   = Remainder;
    div_by_zero_d = DivByZero;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          rem_d   = '0;
          quo_d   = abs_dividend;
          dvsr_d  = abs_divisor;
          count_d = '0;
          if (Divisor == '0) begin
            state_d       = StDone;
            quotient_d    = '1;
            remainder_d   = Dividend;
            div_by_zero_d = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          state_d       = StDone;
          quotient_d    = fix_quo;
          remainder_d   = fix_rem;
          div_by_zero_d = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      Quotient  <= quotient_d;
      Remainder <= remainder_d;
      DivByZero <= div_by_zero_d;
    end
  end

  // Combinational from Start so the request cycle itself stalls.
  assign DivStall = rst && (accept || (state_q == StBusy));
  assign Done     = (state_q == StDone);

endmodule

// File: tb/tb_iterative_divider.sv
// Randomised and directed bench for iterative_divider against an arithmetic reference model.
module tb_iterative_divider;

  localparam int unsigned W = 16;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         Start;
  logic         Signed;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic         DivStall;
  logic         Done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         DivByZero;

  int vectors;
  int miscompares;

  iterative_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .Signed   (Signed),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .DivStall (DivStall),
    .Done     (Done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivByZero(DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    int sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (s && SignedEn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle; returns in the DONE cycle when keep is set, else one cycle later.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit keep);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat, cycles, stalls;
    model(a, b, s, eq, er, ez);
    lat      = (b == '0) ? 1 : W + 1;
    Dividend = a;
    Divisor  = b;
    Signed   = s;
    Start    = 1'b1;
    #1;
    check("req_stall", 32'(DivStall), 32'd1);
    stalls = 1;
    cycles = 0;
    while (cycles < 40) begin
      tick();
      cycles++;
      if (Done) break;
      if (DivStall) stalls++;
    end
    check("latency", 32'(cycles), 32'(lat));
    check("stall_cycles", 32'(stalls), 32'(lat));
    check("done_nostall", 32'(DivStall), 32'd0);
    check("quotient", 32'(Quotient), 32'(eq));
    check("remainder", 32'(Remainder), 32'(er));
    check("div_by_zero", 32'(DivByZero), 32'(ez));
    if (!keep) begin
      Start = 1'b0;
      tick();
      check("done_pulse", 32'(Done), 32'd0);
      check("idle_stall", 32'(DivStall), 32'd0);
    end
  endtask

  initial begin
    int  done_cnt;
    int  sel;
    logic [W-1:0] ra, rb;
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    Start    = 1'b1;
    Signed   = 1'b0;
    Dividend = 16'd5;
    Divisor  = 16'd1;
    tick();
    tick();
    check("rst_stall", 32'(DivStall), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_quo", 32'(Quotient), 32'd0);
    check("rst_rem", 32'(Remainder), 32'd0);
    check("rst_dbz", 32'(DivByZero), 32'd0);
    Start = 1'b0;
    rst   = 1'b1;
    tick();

    do_div(16'd100, 16'd7, 1'b0, 1'b0);
    do_div(16'hFF9C, 16'd7, 1'b1, 1'b0);
    do_div(16'd100, 16'hFFF9, 1'b1, 1'b0);
    do_div(16'd1234, 16'd0, 1'b0, 1'b0);
    do_div(16'd9, 16'd3, 1'b0, 1'b0);
    do_div(16'hFF9C, 16'd0, 1'b1, 1'b0);
    do_div(16'h8000, 16'hFFFF, 1'b1, 1'b0);
    do_div(16'hFFFF, 16'd1, 1'b0, 1'b0);

    // Start held through DONE: one pulse, then a fresh accept in the following IDLE cycle.
    do_div(16'd200, 16'd9, 1'b0, 1'b1);
    tick();
    check("single_pulse", 32'(Done), 32'd0);
    do_div(16'd50, 16'd5, 1'b0, 1'b0);

    // Reset in the middle of BUSY.
    Dividend = 16'd100;
    Divisor  = 16'd7;
    Signed   = 1'b0;
    Start    = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    Start = 1'b0;
    rst   = 1'b0;
    #1;
    check("mid_rst_stall", 32'(DivStall), 32'd0);
    tick();
    rst = 1'b1;
    check("post_rst_done", 32'(Done), 32'd0);
    check("post_rst_stall", 32'(DivStall), 32'd0);
    check("post_rst_quo", 32'(Quotient), 32'd0);
    check("post_rst_rem", 32'(Remainder), 32'd0);
    check("post_rst_dbz", 32'(DivByZero), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Done) done_cnt++;
    end
    check("abandoned_op", 32'(done_cnt), 32'd0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = W'($urandom);
      if (sel == 0) rb = '0;
      else if (sel < 4) rb = W'($urandom_range(1, 15));
      else rb = W'($urandom);
      if (i < 39 && $urandom_range(0, 3) == 0) begin
        do_div(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
        tick();
        check("rand_pulse", 32'(Done), 32'd0);
      end else begin
        do_div(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
